// File: rtl/lstm_gate_weight_bank.sv
// NUM_GATES parallel weight banks sharing one burst read pointer; LSTM_WEIGHT_BANK_WR_BYPASS_EN selects write-first forwarding.
// Latency: command accepted at T, first beat valid at T+2, then 1 beat/cycle; out_ready low holds the 2-entry skid FIFO head and stalls issue.
module lstm_gate_weight_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int READ_BURST = 2,
  parameter int NUM_GATES  = 4,
  parameter int DEPTH      = 8192,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                wr_en,
  input  logic [(NUM_GATES > 1 ? $clog2(NUM_GATES) : 1)-1:0]  wr_gate,
  input  logic [ADDR_WIDTH-1:0]                               wr_addr,
  input  logic [DATA_WIDTH*READ_BURST-1:0]                    wr_data,
  input  logic                                                cmd_valid,
  output logic                                                cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                               cmd_start,
  input  logic [ADDR_WIDTH:0]                                 cmd_len,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [NUM_GATES*DATA_WIDTH*READ_BURST-1:0]          out_data,
  output logic                                                out_last,
  output logic                                                busy,
  output logic                                                done
);
  localparam int W  = DATA_WIDTH * READ_BURST;
  localparam int GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int OW = NUM_GATES * W;
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_issued;
  logic                  r_rd_vld;
  logic                  r_rd_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cmd_ready;
  logic [OW-1:0]         r_fifo_dat [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_count;

  wire  [OW-1:0]         w_rd_word;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_last_hs;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo_dat[r_rp];
  assign out_last  = r_fifo_last[r_rp];
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_cmd_ready;

  assign w_push    = r_rd_vld;
  assign w_pop     = out_valid & out_ready;
  assign w_last_hs = w_pop & out_last;
  // The beat leaving this cycle frees its slot, so a full-rate stream never throttles.
  assign w_room    = ({1'b0, r_count} + {2'b00, r_rd_vld}) < (3'd2 + {2'b00, w_pop});
  assign w_issue   = (r_state == STREAM) && (r_issued < r_len) && w_room;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_bank
    localparam logic [GW-1:0] GIDX = GW'(g);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_lane;
    logic         w_wr_hit;

    assign w_wr_hit = wr_en && (wr_gate == GIDX);

    always_ff @(posedge clk) begin
      if (w_wr_hit) r_mem[wr_addr] <= wr_data;
      if (w_issue) begin
`ifdef LSTM_WEIGHT_BANK_WR_BYPASS_EN
        if (w_wr_hit && (wr_addr == r_ptr)) r_lane <= wr_data;
        else                                r_lane <= r_mem[r_ptr];
`else
        r_lane <= r_mem[r_ptr];
`endif
      end
    end

    assign w_rd_word[g*W +: W] = r_lane;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_done    <= 1'b0;
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && (r_issued == r_len - LW'(1));
      if (w_issue) begin
        r_ptr    <= r_ptr + ADDR_WIDTH'(1);
        r_issued <= r_issued + LW'(1);
      end
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_ptr    <= cmd_start;
            r_len    <= cmd_len;
            r_issued <= '0;
            if (cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= STREAM;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
            end
          end
        end
        STREAM: begin
          if (w_issue && ((r_issued + LW'(1)) == r_len)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_last_hs) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_dat[0] <= '0;
      r_fifo_dat[1] <= '0;
      r_fifo_last   <= '0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wp]  <= w_rd_word;
        r_fifo_last[r_wp] <= r_rd_last;
        r_wp              <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_gate_weight_bank.sv
// Directed bench for lstm_gate_weight_bank: write-port preload, scoreboard of expected beats, immediate assertions.
module tb_lstm_gate_weight_bank;
  localparam int DW = 16, RB = 2, NG = 4, DEPTH = 8192, AW = 13;
  localparam int W = DW * RB, OW = NG * W, GW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [GW-1:0] wr_gate;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_start;
  logic [AW:0]   cmd_len;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  lstm_gate_weight_bank #(
    .DATA_WIDTH(DW), .READ_BURST(RB), .NUM_GATES(NG), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_gate(wr_gate), .wr_addr(wr_addr),
    .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [OW-1:0] dat;
    logic          last;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] mm [int];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_done = 0;
  int           n_pop = 0;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] pat(input int g, input int a);
    return {g[15:0], a[15:0]};
  endfunction

  function automatic logic [OW-1:0] word_at(input int a);
    logic [OW-1:0] w;
    w = '0;
    for (int g = 0; g < NG; g++) w[g*W +: W] = mm[g*DEPTH + a];
    return w;
  endfunction

  // One clock: observe outputs at the falling edge, return just after the next rising edge.
  task automatic step();
    beat_t b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", out_valid, 0);
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", out_data, b.dat);
        chk("beat_last", out_last, b.last);
        n_pop++;
      end
    end else if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_valid", out_valid, 0);
      else                   chk("stall_data", out_data, exp_q[0].dat);
    end
    if (done) n_done++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int g, input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_gate = g[GW-1:0];
    wr_addr = a[AW-1:0];
    wr_data = d;
    mm[g*DEPTH + a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic preload(input int a0, input int n);
    for (int a = a0; a < a0 + n; a++)
      for (int g = 0; g < NG; g++) do_write(g, a, pat(g, a));
  endtask

  task automatic send_cmd(input int start, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.dat  = word_at((start + i) % DEPTH);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = start[AW-1:0];
    cmd_len   = len[AW:0];
    step();
    cmd_valid = 1'b0;
  endtask

  // mode 1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic wait_done(input string tag, input int mode);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 300) begin
      out_ready = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step();
      k++;
    end
    out_ready = 1'b1;
    chk({tag, "_done_count"}, n_done - d0, 1);
    chk({tag, "_all_beats"}, exp_q.size(), 0);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int    p0;
    int    d0;
    int    k;
    beat_t tb;

    rst = 1'b1; wr_en = 1'b0; wr_gate = '0; wr_addr = '0; wr_data = '0;
    cmd_valid = 1'b0; cmd_start = '0; cmd_len = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;

    preload(0, 2);
    preload(8190, 2);
    preload(10, 4);
    preload(18, 4);
    preload(30, 6);
    preload(40, 8);
    preload(50, 4);
    preload(60, 4);

    // Basic burst with exact cycle timing.
    send_cmd(10, 4);
    chk("lat_t0_valid", out_valid, 0);
    step();
    chk("lat_t1_valid", out_valid, 0);
    chk("lat_t1_busy", busy, 1);
    step();
    chk("lat_t2_valid", out_valid, 1);
    p0 = n_pop;
    repeat (4) step();
    chk("basic_beats", n_pop - p0, 4);
    chk("basic_done", done, 1);
    chk("basic_busy", busy, 0);
    step();
    chk("basic_done_low", done, 0);
    chk("basic_cmd_ready", cmd_ready, 1);

    send_cmd(8190, 4);
    wait_done("wrap", 0);

    send_cmd(30, 6);
    wait_done("backpressure", 1);

    do_write(2, 20, 32'h0000_BEEF);
    send_cmd(18, 4);
    wait_done("write_before", 0);

    // Write lands on gate 1 addr 52 in the same cycle that address is issued.
    send_cmd(50, 4);
`ifdef LSTM_WEIGHT_BANK_WR_BYPASS_EN
    tb = exp_q[2];
    tb.dat[W +: W] = 32'h1234_5678;
    exp_q[2] = tb;
`endif
    step();
    step();
    wr_en = 1'b1; wr_gate = 2'd1; wr_addr = 13'd52; wr_data = 32'h1234_5678;
    mm[1*DEPTH + 52] = 32'h1234_5678;
    step();
    wr_en = 1'b0;
    wait_done("collision", 0);
    send_cmd(52, 1);
    wait_done("collision_after", 0);

    // Abort a burst with reset after two beats.
    send_cmd(40, 8);
    p0 = n_pop;
    k  = 0;
    while (n_pop - p0 < 2 && k < 50) begin
      step();
      k++;
    end
    chk("abort_two_beats", n_pop - p0, 2);
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    out_ready = 1'b1;
    d0 = n_done;
    repeat (4) step();
    chk("abort_no_done", n_done - d0, 0);
    send_cmd(60, 4);
    wait_done("after_abort", 0);

    // Zero-length command, immediately followed by a real one.
    send_cmd(0, 0);
    chk("len0_done", done, 1);
    chk("len0_cmd_ready", cmd_ready, 1);
    chk("len0_out_valid", out_valid, 0);
    send_cmd(0, 2);
    chk("len0_follow_done_low", done, 0);
    wait_done("len0_follow", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
